// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable little-endian data memory with sized loads/stores and post-reset clear.
module data_memory_ctrl #(
  parameter int DEPTH_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        ready_o
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_data;
  logic            r_valid, r_err, r_ready;
  logic [7:0]      r_mem [DEPTH_BYTES];
  logic [AW-1:0]   w_b;
  logic [3:0]      w_be;
  logic            w_acc, w_bad, w_ok;
  logic [7:0]      w_rb [4];
  logic [31:0]     w_raw, w_ld;
  always_comb begin
    w_b   = addr_i[AW-1:0];
    w_be  = size_i == 2'b00 ? 4'b0001 : size_i == 2'b01 ? 4'b0011 : 4'b1111;
    w_acc = r_state == RUN && (MemRead_i || MemWrite_i);
    w_bad = size_i == 2'b11 || addr_i >= 32'(DEPTH_BYTES) ||
            (size_i == 2'b01 && addr_i[0]) || (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    w_ok  = w_acc && !w_bad;
    for (int k = 0; k < 4; k++) w_rb[k] = r_mem[w_b + AW'(k)];
    w_raw = {w_rb[3], w_rb[2], w_rb[1], w_rb[0]};
    w_ld  = size_i == 2'b00 ? {{24{~unsigned_i & w_raw[7]}}, w_raw[7:0]} :
            size_i == 2'b01 ? {{16{~unsigned_i & w_raw[15]}}, w_raw[15:0]} : w_raw;
  end
  // Reads sample the array before this edge's store lands, giving read-first behaviour.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (r_state == CLEAR) r_mem[r_idx + AW'(k)] <= '0;
      else if (w_ok && MemWrite_i && w_be[k]) r_mem[w_b + AW'(k)] <= data_i[8*k +: 8];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= CLEAR;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == CLEAR) begin
        r_idx <= r_idx + AW'(4);
        if (r_idx == AW'(DEPTH_BYTES - 4)) begin
          r_state <= RUN;
          r_ready <= 1'b1;
        end
      end else if (w_acc) begin
        if (w_bad) begin
          r_err <= 1'b1;
          if (MemRead_i) r_data <= '0;
        end else if (MemRead_i) begin
          r_data  <= w_ld;
          r_valid <= 1'b1;
        end
      end
    end
  end
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign err_o   = r_err;
  assign ready_o = r_ready;
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, byte-addressable, little-endian data memory for the single-cycle/pipelined CPU datapath, with byte/half/word load-store sizes, sign or zero extension on loads, alignment and range checking, and a post-reset clear sequencer. It sits on the MEM stage and serves lw/sw, lh/lhu/sh and lb/lbu/sb. Read data is registered, arriving one cycle after the request, and is qualified by a valid strobe.

## Interface
- DEPTH_BYTES, 32: memory size in bytes; power of two, at least 4.
- AW, log2(DEPTH_BYTES): number of internal byte-index bits; derived, not overridden.
- clk_i  in  1  clock; everything is sampled on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- addr_i  in  32  byte address.
- data_i  in  32  store data; the low bytes are used for sub-word stores.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request.
- size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (error).
- unsigned_i  in  1  1 zero-extends loads, 0 sign-extends them; ignored for word access.
- data_o  out  32  registered load data.
- valid_o  out  1  one-cycle pulse; data_o holds a new load result.
- err_o  out  1  one-cycle pulse; the previous cycle's request was rejected.
- ready_o  out  1  1 means requests are accepted; 0 during the clear sequence.

## Operation
- The FSM has two states, CLEAR and RUN. rst_i forces CLEAR with clear index 0.
- In CLEAR:
  - One aligned 32-bit word is written to zero per cycle, at word index 0 up to DEPTH_BYTES/4-1.
  - After the last word the FSM moves to RUN.
  - ready_o is 0. MemRead_i and MemWrite_i are ignored, with no error and no valid.
- In RUN, a request is accepted when MemRead_i or MemWrite_i is 1.
- Request checks, in priority order:
  - size_i=11 gives an error.
  - addr_i >= DEPTH_BYTES gives an error.
  - Misalignment gives an error: half with addr_i[0]=1, or word with addr_i[1:0]≠00.
- A rejected request does not modify memory. It sets err_o=1 next cycle. If it was a read, it also sets data_o=0 and valid_o=0 next cycle.
- Stores are little-endian with byte index b = addr_i[AW-1:0]:
  - byte: mem[b] is data_i[7:0].
  - half: mem[b] is data_i[7:0] and mem[b+1] is data_i[15:8].
  - word: mem[b..b+3] is data_i[7:0] through data_i[31:24].
- Loads assemble the same byte order.
  - byte: extend from bit 7.
  - half: extend from bit 15.
  - Extension uses replicated sign bits when unsigned_i=0 and zeros when unsigned_i=1.
- Simultaneous MemRead_i and MemWrite_i is read-first: the load returns the pre-write contents, and the store still commits.
- A single validity check applies to both read and write in the same cycle.
- data_o holds its last value whenever valid_o=0, except on a rejected read, where it is cleared to 0.
- Byte-index arithmetic is AW bits wide. Alignment checking guarantees b+3 never wraps for an accepted word access.

## Timing
- Reset values: data_o=0, valid_o=0, err_o=0, ready_o=0, state CLEAR, clear index 0.
- The clear sequence takes exactly DEPTH_BYTES/4 cycles after rst_i falls. ready_o rises on the edge that completes the last clear write; with the default of 32 it is 1 in the 9th cycle after release.
- Load latency is 1. A request sampled at edge N gives data_o/valid_o updated at edge N+1.
- Store latency is 1. The memory update is visible to a load sampled at edge N+1 or later.
- Back-to-back requests every cycle are supported; there is no stall and no backpressure in RUN.
- err_o and valid_o are never both 1.
- Asserting rst_i at any time, including mid-clear or mid-access, immediately resets the outputs and restarts CLEAR. An in-flight load result is discarded.

## Test plan
- Release reset and sample ready_o each cycle → ready_o=0 for 8 cycles and 1 from the 9th; word loads of all 8 words return 0x00000000.
- sw 0x8899AABB @4, then lb @4, lbu @7, lh @6, lhu @6, lw @4 → 0xFFFFFFBB, 0x00000088, 0xFFFF8899, 0x00008899, 0x8899AABB, each with valid_o pulsed one cycle after its request.
- sb 0x7F @9, then sh 0x1234 @10, then lw @8 → bytes 9..11 read back as 0x7F, 0x34, 0x12 in bits [15:8], [23:16], [31:24]; byte 8 keeps its prior value.
- lw @2, sh @3, sw @32, size_i=11 → err_o=1 for each; memory is unchanged (verified by readback); data_o=0 after the rejected lw.
- Same-cycle MemRead_i+MemWrite_i, word @12, data 0xDEADBEEF, over an old value of 0x01020304 → data_o=0x01020304; the next lw @12 returns 0xDEADBEEF.
- Pulse rst_i during CLEAR (cycle 4) and during a pending load → outputs are 0 at once; CLEAR restarts from index 0 and ready_o rises 8 cycles after the second release.
